multiply_r: RTL and testbench

- Unsigned fixed-point fraction multiplier; the inverse-operation companion to the restoring fraction divider in the FPU datapath.
- Iterative shift-add: consumes BPC multiplier bits per clock.
- Returns the full double-width product, the upper half, and a sticky bit covering the lower half, for downstream rounding.
- Start/done handshake; sits in the FPU mantissa path alongside the divider.

---
 rtl/multiply_r.sv | 106 ++++++++++
 tb/tb_multiply_r.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multiply_r.sv
// Iterative shift-add unsigned fraction multiplier. It retires BPC multiplier bits
// per clock and returns the full product, the upper half and a sticky bit for rounding.
module multiply_r #(
  parameter int WIDTH = 24,
  parameter int BPC   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   prod_hi,
  output logic               sticky
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = 2 * WIDTH + BPC;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_prod;
  logic                 r_sticky;
  logic [SW-1:0]        w_sum;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic                 w_accept;
  logic                 w_last;

  assign w_accept = (r_state != RUN) && start;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);

  // The sum is widened by BPC bits so the carry out of the top partial product
  // survives until the right shift brings it back into the 2*WIDTH accumulator.
  always_comb begin
    w_sum = {{BPC{1'b0}}, r_acc};
    for (int k = 0; k < BPC; k++) begin
      if (r_mplier[k]) begin
        w_sum = w_sum + (SW'(r_mcand) << (WIDTH + k));
      end
    end
    w_acc_next = w_sum[SW-1:BPC];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_sticky <= 1'b0;
    end else if (w_accept) begin
      r_mcand  <= a;
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_acc    <= w_acc_next;
      r_mplier <= r_mplier >> BPC;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_prod   <= w_acc_next;
        r_sticky <= |w_acc_next[WIDTH-1:0];
      end
    end
  end

  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign prod    = r_prod;
  assign prod_hi = r_prod[2*WIDTH-1:WIDTH];
  assign sticky  = r_sticky;

endmodule

// File: tb/tb_multiply_r.sv
// Directed and random checks of multiply_r at BPC = 1, 2 and 4 (WIDTH = 24).
module tb_multiply_r;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_v  [3];
  logic [23:0] a_v      [3];
  logic [23:0] b_v      [3];
  logic        busy_v   [3];
  logic        done_v   [3];
  logic [47:0] prod_v   [3];
  logic [23:0] hi_v     [3];
  logic        sticky_v [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multiply_r #(.WIDTH(24), .BPC(1)) u_bpc1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .prod(prod_v[0]), .prod_hi(hi_v[0]),
    .sticky(sticky_v[0]));

  multiply_r #(.WIDTH(24), .BPC(2)) u_bpc2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .prod(prod_v[1]), .prod_hi(hi_v[1]),
    .sticky(sticky_v[1]));

  multiply_r #(.WIDTH(24), .BPC(4)) u_bpc4 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .prod(prod_v[2]), .prod_hi(hi_v[2]),
    .sticky(sticky_v[2]));

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] p;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int s, input logic [23:0] ta, input logic [23:0] tb);
    a_v[s]     = ta;
    b_v[s]     = tb;
    start_v[s] = 1'b1;
    tick();
    start_v[s] = 1'b0;
    a_v[s]     = 24'($urandom);
    b_v[s]     = 24'($urandom);
  endtask

  // Waits up to n+10 edges for done; expects it exactly n edges after the call.
  task automatic wait_done(input int s, input logic [47:0] exp, input int n, input string nm);
    logic [47:0] held;
    int          lat;
    bit          seen;
    bit          bad_busy;
    bit          bad_hold;
    held     = prod_v[s];
    lat      = 0;
    seen     = 1'b0;
    bad_busy = 1'b0;
    bad_hold = 1'b0;
    while (!seen && lat < n + 10) begin
      tick();
      lat++;
      if (done_v[s]) seen = 1'b1;
      else begin
        if (!busy_v[s]) bad_busy = 1'b1;
        if (prod_v[s] !== held) bad_hold = 1'b1;
      end
    end
    check({nm, " done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({nm, " latency"}, 64'(lat), 64'(n));
      check({nm, " busy_in_run"}, 64'(bad_busy), 64'd0);
      check({nm, " prod_hold"}, 64'(bad_hold), 64'd0);
      check({nm, " busy_in_done"}, 64'(busy_v[s]), 64'd0);
      check({nm, " prod"}, 64'(prod_v[s]), 64'(exp));
      check({nm, " prod_hi"}, 64'(hi_v[s]), 64'(exp[47:24]));
      check({nm, " sticky"}, 64'(sticky_v[s]), 64'(|exp[23:0]));
    end
  endtask

  initial begin
    bit          bad;
    logic [23:0] ra;
    logic [23:0] rb;

    vecs[0] = '{24'h800000, 24'h800000, 48'h400000000000};
    vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
    vecs[2] = '{24'h000000, 24'hABCDEF, 48'h000000000000};
    vecs[3] = '{24'h000003, 24'h000005, 48'h00000000000F};
    vecs[4] = '{24'h000001, 24'hFFFFFF, 48'h000000FFFFFF};
    vecs[5] = '{24'h123456, 24'h000010, 48'h000001234560};
    vecs[6] = '{24'hFFFFFF, 24'h000002, 48'h000001FFFFFE};
    vecs[7] = '{24'h100000, 24'h000100, 48'h000010000000};
    vecs[8] = '{24'hABCDEF, 24'h000000, 48'h000000000000};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      a_v[i]     = '0;
      b_v[i]     = '0;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset busy%0d", i), 64'(busy_v[i]), 64'd0);
      check($sformatf("reset done%0d", i), 64'(done_v[i]), 64'd0);
      check($sformatf("reset prod%0d", i), 64'(prod_v[i]), 64'd0);
      check($sformatf("reset sticky%0d", i), 64'(sticky_v[i]), 64'd0);
    end
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      launch(0, vecs[i].a, vecs[i].b);
      wait_done(0, vecs[i].p, 24, $sformatf("vec%0d", i));
      tick();
      check($sformatf("vec%0d done_pulse", i), 64'(done_v[0]), 64'd0);
    end

    // Start pulsed mid-run must be ignored; then back-to-back start in DONE.
    launch(0, 24'h000003, 24'h000005);
    for (int e = 1; e <= 5; e++) begin
      if (e == 5) begin
        start_v[0] = 1'b1;
        a_v[0]     = 24'hFFFFFF;
        b_v[0]     = 24'hFFFFFF;
      end
      tick();
    end
    start_v[0] = 1'b0;
    wait_done(0, 48'h00000000000F, 19, "ignored_start");
    launch(0, 24'h000002, 24'h000002);
    wait_done(0, 48'h000000000004, 24, "back_to_back");
    tick();

    // Reset mid-run discards the operation; rst also beats a coincident start.
    launch(0, 24'hFFFFFF, 24'hFFFFFF);
    for (int e = 1; e <= 9; e++) tick();
    rst        = 1'b1;
    start_v[0] = 1'b1;
    a_v[0]     = 24'h000007;
    b_v[0]     = 24'h000007;
    tick();
    check("midrst busy", 64'(busy_v[0]), 64'd0);
    check("midrst done", 64'(done_v[0]), 64'd0);
    check("midrst prod", 64'(prod_v[0]), 64'd0);
    check("midrst prod_hi", 64'(hi_v[0]), 64'd0);
    check("midrst sticky", 64'(sticky_v[0]), 64'd0);
    tick();
    rst        = 1'b0;
    start_v[0] = 1'b0;
    bad        = 1'b0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (done_v[0] || busy_v[0]) bad = 1'b1;
    end
    check("postrst quiet", 64'(bad), 64'd0);
    launch(0, 24'hFFFFFF, 24'hFFFFFF);
    wait_done(0, 48'hFFFFFE000001, 24, "postrst op");
    tick();

    for (int s = 1; s < 3; s++) begin
      launch(s, 24'hFFFFFF, 24'hFFFFFF);
      wait_done(s, 48'hFFFFFE000001, (s == 1) ? 12 : 6, $sformatf("max_bpc%0d", s * 2));
      tick();
      for (int i = 0; i < 1000; i++) begin
        ra = 24'($urandom);
        rb = 24'($urandom);
        launch(s, ra, rb);
        wait_done(s, 48'(ra) * 48'(rb), (s == 1) ? 12 : 6,
                  $sformatf("rnd_bpc%0d_%0d", s * 2, i));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
